// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with its own HI/LO pair.
// One shift-add or restoring shift-subtract step per CALC cycle, sign fix-up in FIX.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiWre,
  input  logic             LoWre,
  input  logic [WIDTH-1:0] MoveData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc;         // product high half / partial remainder
  logic [WIDTH-1:0] low;         // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] mcand;       // |multiplicand| or |divisor|
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             b_zero;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             last_step;
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fix;
  logic [WIDTH-1:0] hi_fix;
  logic [WIDTH-1:0] lo_fix;

  assign last_step = (count == CW'(WIDTH - 1));

  // ---------------- state machine ----------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = CALC;
      CALC:    if (last_step) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- operand preparation ----------------
  always_comb begin
    op_signed = ~Op[0];
    a_neg     = op_signed & OperandA[WIDTH-1];
    b_neg     = op_signed & OperandB[WIDTH-1];
    abs_a     = a_neg ? (~OperandA + 1'b1) : OperandA;
    abs_b     = b_neg ? (~OperandB + 1'b1) : OperandB;
  end

  // ---------------- iteration step ----------------
  always_comb begin
    mul_sum   = low[0] ? (acc + {1'b0, mcand}) : acc;
    div_shift = {acc[WIDTH-1:0], low[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
  end

  // ---------------- sign correction ----------------
  always_comb begin
    product     = {acc[WIDTH-1:0], low};
    product_fix = neg_res ? (~product + 1'b1) : product;
    if (is_div) begin
      lo_fix = b_zero ? {WIDTH{1'b1}} : (neg_res ? (~low + 1'b1) : low);
      // A zero divisor leaves |A| as remainder, so the dividend-sign fix restores A exactly.
      hi_fix = neg_rem ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    end else begin
      lo_fix = product_fix[WIDTH-1:0];
      hi_fix = product_fix[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count   <= '0;
      acc     <= '0;
      low     <= '0;
      mcand   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            count   <= '0;
            acc     <= '0;
            is_div  <= Op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (OperandB == '0);
            low     <= Op[1] ? abs_a : abs_b;
            mcand   <= Op[1] ? abs_b : abs_a;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (is_div) begin
            acc <= div_diff[WIDTH] ? div_shift : div_diff;
            low <= {low[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc <= {1'b0, mul_sum[WIDTH:1]};
            low <= {mul_sum[0], low[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- HI/LO and status ----------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      dbz_q  <= (state == FIX) & is_div & b_zero;
      if (state == FIX) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end else if (state == IDLE && !Start) begin
        if (HiWre) hi_q <= MoveData;
        if (LoWre) lo_q <= MoveData;
      end
    end
  end

  assign Busy      = (state != IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule
